// File: rtl/mu0_pkg.sv
// MU0 shared definitions: opcodes, ALU function codes, default widths.
// Latency: none (constants only).
// Backpressure: none.
package mu0_pkg;

    localparam int DW = 16;
    localparam int AW = 12;

    // Instruction opcodes (IR[DW-1:AW])
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    // ALU function select (M)
    localparam logic [1:0] ALU_LOAD = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_INC  = 2'b10;
    localparam logic [1:0] ALU_SUB  = 2'b11;

endpackage

// File: rtl/mu0_datapath_if.sv
// MU0 control-word / memory / status bundle between control FSM, memory and datapath.
// Latency: none (wires only).
// Backpressure: none; the datapath executes one control word per cycle.
//
// master: control FSM + memory side (drives control word and mem_din).
// slave : datapath (drives mem_addr/mem_dout/mem_we and status back to FSM).
interface mu0_datapath_if #(
    parameter int DW = mu0_pkg::DW,
    parameter int AW = mu0_pkg::AW
);
    // control word
    logic          reset;
    logic          Asel;
    logic          Xsel;
    logic          Ysel;
    logic [1:0]    M;
    logic          PCce;
    logic          IRce;
    logic          ACCce;
    logic          MemRW;
    // memory bus
    logic [DW-1:0] mem_din;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic          mem_we;
    // status back to the FSM / debug
    logic [DW-AW-1:0] opcode;
    logic          ACCmsb;
    logic          ACCor;
    logic          halted;
    logic [15:0]   instr_count;

    modport master (
        output reset, Asel, Xsel, Ysel, M, PCce, IRce, ACCce, MemRW, mem_din,
        input  mem_addr, mem_dout, mem_we, opcode, ACCmsb, ACCor, halted, instr_count
    );

    modport slave (
        input  reset, Asel, Xsel, Ysel, M, PCce, IRce, ACCce, MemRW, mem_din,
        output mem_addr, mem_dout, mem_we, opcode, ACCmsb, ACCor, halted, instr_count
    );

endinterface

// File: rtl/mu0_alu.sv
// MU0 ALU: load / add / subtract / address-increment, result modulo 2^DW.
// Latency: combinational.
// Backpressure: none.
//
// Ports: X, Y operands; abus address for increment; mem_din for load; M function; result.
module mu0_alu #(
    parameter int DW = mu0_pkg::DW,
    parameter int AW = mu0_pkg::AW
) (
    input  logic [DW-1:0] X,
    input  logic [DW-1:0] Y,
    input  logic [AW-1:0] abus,
    input  logic [DW-1:0] mem_din,
    input  logic [1:0]    M,
    output logic [DW-1:0] result
);
    import mu0_pkg::*;

    logic [DW-1:0] abus_ext;
    assign abus_ext = {{(DW-AW){1'b0}}, abus};

    always_comb begin
        result = mem_din;
        case (M)
            ALU_LOAD: result = mem_din;
            ALU_ADD:  result = X + Y;
            ALU_INC:  result = abus_ext + DW'(1);
            ALU_SUB:  result = X - Y;
            default:  result = mem_din;
        endcase
    end

endmodule

// File: rtl/mu0_datapath.sv
// MU0 datapath: PC/IR/ACC registers, address and operand muxes, ALU, retired-instruction counter.
// Latency: register updates visible one cycle after the control word; bus/status outputs combinational.
// Backpressure: none; one control word executed every cycle.
//
// Ports: sysclk, ext_reset_n (sync, active-low), bus (slave side: control word in,
// memory bus out, opcode/ACCmsb/ACCor/halted/instr_count status out).
module mu0_datapath #(
    parameter int DW = mu0_pkg::DW,
    parameter int AW = mu0_pkg::AW
) (
    input  logic           sysclk,
    input  logic           ext_reset_n,
    mu0_datapath_if.slave  bus
);
    import mu0_pkg::*;

    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] acc;
    logic [15:0]   icount;

    logic [AW-1:0] abus;
    logic [DW-1:0] x_op;
    logic [DW-1:0] y_op;
    logic [DW-1:0] result;

    // FETCH/JMP load PC and IR together; both muxes read pre-edge register values.
    assign abus = bus.Asel ? ir[AW-1:0] : pc;
    assign x_op = bus.Xsel ? {{(DW-AW){1'b0}}, pc} : acc;
    assign y_op = bus.Ysel ? {{(DW-AW){1'b0}}, ir[AW-1:0]} : bus.mem_din;

    mu0_alu #(.DW(DW), .AW(AW)) u_alu (
        .X       (x_op),
        .Y       (y_op),
        .abus    (abus),
        .mem_din (bus.mem_din),
        .M       (bus.M),
        .result  (result)
    );

    // External reset clears everything; FSM reset keeps the debug counter.
    // Enables are ignored in any clearing cycle.
    always_ff @(posedge sysclk) begin
        if (!ext_reset_n) begin
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            icount <= '0;
        end else if (bus.reset) begin
            pc  <= '0;
            ir  <= '0;
            acc <= '0;
        end else begin
            if (bus.PCce)  pc  <= result[AW-1:0];
            if (bus.IRce)  ir  <= bus.mem_din;
            if (bus.ACCce) acc <= result;
            if (bus.IRce && (icount != 16'hFFFF)) icount <= icount + 16'd1;
        end
    end

    assign bus.mem_addr    = abus;
    assign bus.mem_dout    = acc;
    assign bus.mem_we      = bus.MemRW;
    assign bus.opcode      = ir[DW-1:AW];
    assign bus.ACCmsb      = acc[DW-1];
    assign bus.ACCor       = |acc;
    assign bus.halted      = (ir[DW-1:AW] == OP_STP);
    assign bus.instr_count = icount;

endmodule

// File: tb/tb_mu0_datapath.sv
module tb_mu0_datapath;

    logic sysclk = 1'b0;
    logic ext_reset_n;
    int   errors = 0;
    int   checks = 0;

    mu0_datapath_if bus ();

    mu0_datapath dut (
        .sysclk      (sysclk),
        .ext_reset_n (ext_reset_n),
        .bus         (bus.slave)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a full control word (inputs change well away from the rising edge).
    task automatic cw(input logic asel, input logic xsel, input logic ysel, input logic [1:0] m,
                      input logic pcce, input logic irce, input logic accce, input logic memrw,
                      input logic [15:0] din);
        bus.Asel    = asel;
        bus.Xsel    = xsel;
        bus.Ysel    = ysel;
        bus.M       = m;
        bus.PCce    = pcce;
        bus.IRce    = irce;
        bus.ACCce   = accce;
        bus.MemRW   = memrw;
        bus.mem_din = din;
        #1;
    endtask

    // Apply the current word at the next rising edge, then settle to idle word with Asel.
    task automatic tick(input logic asel_after);
        @(posedge sysclk);
        #1;
        cw(asel_after, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        // reset with every enable on and all-ones data
        ext_reset_n = 1'b0;
        bus.reset   = 1'b0;
        cw(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF);
        repeat (2) @(posedge sysclk);
        #2;
        chk("rst_pc", 32'(bus.mem_addr), 32'h000);
        chk("rst_acc", 32'(bus.mem_dout), 32'h0000);
        chk("rst_accor", 32'(bus.ACCor), 32'h0);
        chk("rst_count", 32'(bus.instr_count), 32'h0000);
        cw(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        ext_reset_n = 1'b1;
        chk("rst_ir_addr", 32'(bus.mem_addr), 32'h000);
        chk("rst_opcode", 32'(bus.opcode), 32'h0);
        chk("rst_msb", 32'(bus.ACCmsb), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_we", 32'(bus.mem_we), 32'h0);

        // PC <- 005 via load path, then FETCH with 2123
        cw(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005);
        tick(1'b0);
        cw(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2123);
        chk("fetch_addr", 32'(bus.mem_addr), 32'h005);
        tick(1'b0);
        chk("fetch_pc", 32'(bus.mem_addr), 32'h006);
        chk("fetch_opcode", 32'(bus.opcode), 32'h2);
        chk("fetch_count", 32'(bus.instr_count), 32'd1);
        cw(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("fetch_ir_addr", 32'(bus.mem_addr), 32'h123);

        // PC wrap FFF -> 000
        cw(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0FFF);
        tick(1'b0);
        cw(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("wrap_addr", 32'(bus.mem_addr), 32'hFFF);
        tick(1'b0);
        chk("wrap_pc", 32'(bus.mem_addr), 32'h000);
        chk("wrap_count", 32'(bus.instr_count), 32'd2);

        // ADD 7FFF + 0001
        cw(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFF);
        tick(1'b1);
        chk("lda_acc", 32'(bus.mem_dout), 32'h7FFF);
        chk("lda_msb", 32'(bus.ACCmsb), 32'h0);
        cw(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001);
        tick(1'b1);
        chk("add_acc", 32'(bus.mem_dout), 32'h8000);
        chk("add_msb", 32'(bus.ACCmsb), 32'h1);

        // SUB 0000 - 0001
        cw(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick(1'b1);
        chk("zero_accor", 32'(bus.ACCor), 32'h0);
        cw(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001);
        tick(1'b1);
        chk("sub_acc", 32'(bus.mem_dout), 32'hFFFF);
        chk("sub_accor", 32'(bus.ACCor), 32'h1);

        // JMP with IR=4ABC, mem_din=0123
        cw(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4ABC);
        tick(1'b0);
        chk("jmpir_opcode", 32'(bus.opcode), 32'h4);
        cw(1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0123);
        chk("jmp_addr", 32'(bus.mem_addr), 32'hABC);
        tick(1'b0);
        chk("jmp_pc", 32'(bus.mem_addr), 32'hABD);
        chk("jmp_opcode", 32'(bus.opcode), 32'h0);
        chk("jmp_count", 32'(bus.instr_count), 32'd4);
        cw(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("jmp_ir_addr", 32'(bus.mem_addr), 32'h123);

        // STO with IR=1040, ACC=1234
        cw(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1040);
        tick(1'b0);
        cw(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
        tick(1'b0);
        cw(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        chk("sto_addr", 32'(bus.mem_addr), 32'h040);
        chk("sto_dout", 32'(bus.mem_dout), 32'h1234);
        chk("sto_we", 32'(bus.mem_we), 32'h1);
        tick(1'b0);
        chk("sto_pc", 32'(bus.mem_addr), 32'hABD);
        chk("sto_acc", 32'(bus.mem_dout), 32'h1234);
        chk("sto_opcode", 32'(bus.opcode), 32'h1);
        chk("sto_we_off", 32'(bus.mem_we), 32'h0);
        cw(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("sto_ir_addr", 32'(bus.mem_addr), 32'h040);
        chk("sto_count", 32'(bus.instr_count), 32'd5);

        // FSM reset overrides enables, keeps counter
        bus.reset = 1'b1;
        cw(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h5555);
        tick(1'b0);
        bus.reset = 1'b0;
        #1;
        chk("clr_pc", 32'(bus.mem_addr), 32'h000);
        chk("clr_acc", 32'(bus.mem_dout), 32'h0000);
        chk("clr_opcode", 32'(bus.opcode), 32'h0);
        chk("clr_count", 32'(bus.instr_count), 32'd5);
        cw(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("clr_ir_addr", 32'(bus.mem_addr), 32'h000);

        // STP opcode raises halted
        cw(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7000);
        tick(1'b0);
        chk("stp_halted", 32'(bus.halted), 32'h1);
        chk("stp_count", 32'(bus.instr_count), 32'd6);

        // Counter saturation over 70000 fetches
        cw(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2000);
        repeat (70000) @(posedge sysclk);
        #1;
        cw(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("sat_count", 32'(bus.instr_count), 32'hFFFF);
        tick(1'b0);
        chk("sat_hold", 32'(bus.instr_count), 32'hFFFF);

        // External reset clears the counter
        ext_reset_n = 1'b0;
        tick(1'b0);
        ext_reset_n = 1'b1;
        #1;
        chk("xrst_count", 32'(bus.instr_count), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
